svm_batch_dispatcher: RTL and testbench

- Consumer at the far end of the scheduler's output AXI-Stream. Receives scheduled transactions (owner programID plus read/write dependency vectors) and dispatches each to one of NUM_LANES execution lanes.
- Tracks the dependencies of in-flight transactions and stalls any new transaction that conflicts with them (RAW/WAW/WAR safety net across batch boundaries).
- Releases lanes on per-lane completion pulses and exports dispatch, completion and stall statistics.

---
 rtl/svm_batch_dispatcher.sv | 152 +++++++++++++++
 tb/tb_svm_batch_dispatcher.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_batch_dispatcher.sv
// Dispatches scheduled transactions from a single-entry hold stage to the lowest free
// execution lane, stalling any transaction whose dependencies overlap work still in flight.
module svm_batch_dispatcher #(
  parameter int MAX_DEPENDENCIES = 256,
  parameter int NUM_LANES        = 4,
  parameter int LANE_ID_W        = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [63:0]                 s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic [NUM_LANES-1:0]        lane_start,
  output logic [63:0]                 lane_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] lane_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] lane_write_dependencies,
  input  logic [NUM_LANES-1:0]        lane_done,
  output logic [NUM_LANES-1:0]        lane_busy,
  output logic                        idle,
  output logic [31:0]                 dispatched_count,
  output logic [31:0]                 completed_count,
  output logic [31:0]                 conflict_stall_cycles,
  output logic                        done_error
);

  // Valid/ready: a transaction transfers at a rising edge where s_axis_tvalid and
  // s_axis_tready are both high; tready is high when the hold stage is empty or
  // is being dispatched in this same cycle.

  logic                        hold_valid;
  logic [63:0]                 hold_owner;
  logic [MAX_DEPENDENCIES-1:0] hold_r;
  logic [MAX_DEPENDENCIES-1:0] hold_w;

  logic [MAX_DEPENDENCIES-1:0] lane_rd [NUM_LANES];
  logic [MAX_DEPENDENCIES-1:0] lane_wr [NUM_LANES];

  logic [MAX_DEPENDENCIES-1:0] busy_r;
  logic [MAX_DEPENDENCIES-1:0] busy_w;
  logic                        conflict;
  logic                        free_any;
  logic                        dispatch_fire;
  logic                        load;
  logic [LANE_ID_W-1:0]        sel_idx;
  logic                        sel_found;
  logic [NUM_LANES-1:0]        sel_oh;
  logic [NUM_LANES-1:0]        done_valid;
  logic [31:0]                 done_cnt;

  always_comb begin
    busy_r = '0;
    busy_w = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_busy[i]) begin
        busy_r = busy_r | lane_rd[i];
        busy_w = busy_w | lane_wr[i];
      end
    end
  end

  assign conflict = (|(busy_w & hold_r)) || (|(busy_w & hold_w)) || (|(busy_r & hold_w));
  assign free_any = |(~lane_busy);

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!lane_busy[i] && !sel_found) begin
        sel_idx   = LANE_ID_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign sel_oh        = {{(NUM_LANES-1){1'b0}}, 1'b1} << sel_idx;
  assign dispatch_fire = hold_valid && free_any && !conflict;
  assign s_axis_tready = !hold_valid || dispatch_fire;
  assign load          = s_axis_tvalid && s_axis_tready;
  assign idle          = !hold_valid && (lane_busy == '0);

  // Done pulses on idle lanes are flagged, never counted.
  assign done_valid = lane_done & lane_busy;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      done_cnt = done_cnt + 32'(done_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid              <= 1'b0;
      hold_owner              <= '0;
      hold_r                  <= '0;
      hold_w                  <= '0;
      lane_busy               <= '0;
      lane_start              <= '0;
      lane_owner_programID    <= '0;
      lane_read_dependencies  <= '0;
      lane_write_dependencies <= '0;
      dispatched_count        <= '0;
      completed_count         <= '0;
      conflict_stall_cycles   <= '0;
      done_error              <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_rd[i] <= '0;
        lane_wr[i] <= '0;
      end
    end else begin
      if (load) begin
        hold_valid <= 1'b1;
        hold_owner <= s_axis_tdata_owner_programID;
        hold_r     <= s_axis_tdata_read_dependencies;
        hold_w     <= s_axis_tdata_write_dependencies;
      end else if (dispatch_fire) begin
        hold_valid <= 1'b0;
      end

      // The selected lane is not busy, so it can never also be in done_valid.
      lane_busy <= (lane_busy & ~done_valid) | (dispatch_fire ? sel_oh : '0);
      for (int i = 0; i < NUM_LANES; i++) begin
        if (done_valid[i]) begin
          lane_rd[i] <= '0;
          lane_wr[i] <= '0;
        end else if (dispatch_fire && (sel_idx == LANE_ID_W'(i))) begin
          lane_rd[i] <= hold_r;
          lane_wr[i] <= hold_w;
        end
      end

      lane_start <= dispatch_fire ? sel_oh : '0;
      if (dispatch_fire) begin
        lane_owner_programID    <= hold_owner;
        lane_read_dependencies  <= hold_r;
        lane_write_dependencies <= hold_w;
      end

      dispatched_count <= dispatched_count + 32'(dispatch_fire);
      completed_count  <= completed_count + done_cnt;
      if (hold_valid && free_any && conflict) begin
        conflict_stall_cycles <= conflict_stall_cycles + 32'd1;
      end
      if (|(lane_done & ~lane_busy)) begin
        done_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svm_batch_dispatcher.sv
// Bench for svm_batch_dispatcher: directed scenarios plus randomized traffic checked
// against a transaction-level model of lanes, hold entry and statistics.
module tb_svm_batch_dispatcher;

  localparam int NL = 4;
  localparam int DW = 256;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [63:0]    s_axis_tdata_owner_programID;
  logic [DW-1:0]  s_axis_tdata_read_dependencies;
  logic [DW-1:0]  s_axis_tdata_write_dependencies;
  logic [NL-1:0]  lane_start;
  logic [63:0]    lane_owner_programID;
  logic [DW-1:0]  lane_read_dependencies;
  logic [DW-1:0]  lane_write_dependencies;
  logic [NL-1:0]  lane_done;
  logic [NL-1:0]  lane_busy;
  logic           idle;
  logic [31:0]    dispatched_count;
  logic [31:0]    completed_count;
  logic [31:0]    conflict_stall_cycles;
  logic           done_error;

  int checks = 0;
  int errors = 0;

  svm_batch_dispatcher #(.MAX_DEPENDENCIES(DW), .NUM_LANES(NL), .LANE_ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata_owner_programID(s_axis_tdata_owner_programID),
    .s_axis_tdata_read_dependencies(s_axis_tdata_read_dependencies),
    .s_axis_tdata_write_dependencies(s_axis_tdata_write_dependencies),
    .lane_start(lane_start), .lane_owner_programID(lane_owner_programID),
    .lane_read_dependencies(lane_read_dependencies),
    .lane_write_dependencies(lane_write_dependencies),
    .lane_done(lane_done), .lane_busy(lane_busy), .idle(idle),
    .dispatched_count(dispatched_count), .completed_count(completed_count),
    .conflict_stall_cycles(conflict_stall_cycles), .done_error(done_error)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each lane either holds an in-flight transaction (its read/write sets) or is free.
  logic [NL-1:0] m_occ;
  logic [DW-1:0] m_lr [NL];
  logic [DW-1:0] m_lw [NL];
  bit            m_hv;
  logic [63:0]   m_hown;
  logic [DW-1:0] m_hr, m_hw;
  logic [NL-1:0] m_start;
  logic [63:0]   m_oown;
  logic [DW-1:0] m_ord, m_owr;
  logic [31:0]   m_disp, m_comp, m_stall;
  bit            m_err;

  task automatic model_reset();
    m_occ = '0; m_hv = 0; m_hown = '0; m_hr = '0; m_hw = '0;
    m_start = '0; m_oown = '0; m_ord = '0; m_owr = '0;
    m_disp = '0; m_comp = '0; m_stall = '0; m_err = 0;
    for (int i = 0; i < NL; i++) begin m_lr[i] = '0; m_lw[i] = '0; end
  endtask

  function automatic int first_free();
    for (int i = 0; i < NL; i++) if (!m_occ[i]) return i;
    return -1;
  endfunction

  // True when the held transaction overlaps any in-flight one (RAW, WAW or WAR).
  function automatic bit held_conflicts();
    for (int i = 0; i < NL; i++)
      if (m_occ[i] && (((m_lw[i] & m_hr) != '0) || ((m_lw[i] & m_hw) != '0) ||
                       ((m_lr[i] & m_hw) != '0)))
        return 1;
    return 0;
  endfunction

  function automatic bit model_fire();
    return m_hv && (first_free() >= 0) && !held_conflicts();
  endfunction

  function automatic bit exp_tready();
    return !m_hv || model_fire();
  endfunction

  // Advance one clock: DUT edge plus model update from the inputs applied before it.
  task automatic tick();
    int  fl;
    bit  cf, fire, ld;
    fl   = first_free();
    cf   = held_conflicts();
    fire = model_fire();
    ld   = s_axis_tvalid && (!m_hv || fire);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_hv && fl >= 0 && cf) m_stall++;
      m_start = '0;
      for (int i = 0; i < NL; i++) begin
        if (lane_done[i]) begin
          if (m_occ[i]) begin
            m_occ[i] = 1'b0; m_lr[i] = '0; m_lw[i] = '0; m_comp++;
          end else begin
            m_err = 1;
          end
        end
      end
      if (fire) begin
        m_occ[fl] = 1'b1; m_lr[fl] = m_hr; m_lw[fl] = m_hw;
        m_start[fl] = 1'b1;
        m_oown = m_hown; m_ord = m_hr; m_owr = m_hw;
        m_disp++;
      end
      if (ld) begin
        m_hv = 1; m_hown = s_axis_tdata_owner_programID;
        m_hr = s_axis_tdata_read_dependencies; m_hw = s_axis_tdata_write_dependencies;
      end else if (fire) begin
        m_hv = 0;
      end
    end
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_tx(input bit v, input int owner, input int rbit, input int wbit);
    s_axis_tvalid = v;
    s_axis_tdata_owner_programID = 64'(owner);
    s_axis_tdata_read_dependencies = '0;
    s_axis_tdata_write_dependencies = '0;
    if (rbit >= 0) s_axis_tdata_read_dependencies[rbit] = 1'b1;
    if (wbit >= 0) s_axis_tdata_write_dependencies[wbit] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_tx(0, 0, -1, -1);
    lane_done = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_dep();
    logic [DW-1:0] v;
    v = '0;
    v[7:0] = 8'($urandom & $urandom & $urandom);
    if ($urandom_range(0, 7) == 0) v[DW-1] = 1'b1;
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b want 1", s_axis_tready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if (lane_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b want 0000", lane_busy); end
    checks++; if (lane_start !== 4'b0000) begin errors++; $display("FAIL reset_start got %b want 0000", lane_start); end
    checks++; if ({dispatched_count, completed_count, conflict_stall_cycles} !== 96'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", dispatched_count, completed_count, conflict_stall_cycles); end
    checks++; if (done_error !== 1'b0 || lane_owner_programID !== 64'd0) begin
      errors++; $display("FAIL reset_misc got err=%b owner=%0d want 0/0", done_error, lane_owner_programID); end
  endtask

  task automatic test_single();
    do_reset();
    set_tx(1, 1, 0, 1);
    tick();
    set_tx(0, 0, -1, -1);
    checks++; if (lane_start !== 4'b0000) begin errors++; $display("FAIL single_early got %b want 0000", lane_start); end
    tick();
    checks++; if (lane_start !== 4'b0001 || lane_owner_programID !== 64'd1) begin
      errors++; $display("FAIL single_start got %b owner %0d want 0001 owner 1", lane_start, lane_owner_programID); end
    checks++; if (lane_busy !== 4'b0001 || lane_read_dependencies !== DW'(1) || lane_write_dependencies !== DW'(2)) begin
      errors++; $display("FAIL single_busy got %b rd %h wr %h want 0001 1 2", lane_busy, lane_read_dependencies[7:0], lane_write_dependencies[7:0]); end
    tick();
    checks++; if (lane_start !== 4'b0000 || lane_owner_programID !== 64'd1) begin
      errors++; $display("FAIL single_pulse got %b owner %0d want 0000 owner 1", lane_start, lane_owner_programID); end
    lane_done = 4'b0001;
    tick();
    lane_done = '0;
    checks++; if (completed_count !== 32'd1 || idle !== 1'b1 || dispatched_count !== 32'd1) begin
      errors++; $display("FAIL single_done got comp %0d idle %b disp %0d want 1 1 1", completed_count, idle, dispatched_count); end
  endtask

  task automatic test_back_to_back();
    logic [NL-1:0] exp_st [6];
    logic [NL-1:0] got_st [6];
    int owner_n;
    bit acc;
    exp_st = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    do_reset();
    owner_n = 1;
    for (int c = 0; c < 6; c++) begin
      set_tx(owner_n <= 5, owner_n, 2 * (owner_n - 1), 2 * (owner_n - 1) + 1);
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      if (acc) owner_n++;
      got_st[c] = lane_start;
    end
    set_tx(0, 0, -1, -1);
    for (int c = 0; c < 6; c++) begin
      checks++; if (got_st[c] !== exp_st[c]) begin errors++; $display("FAIL b2b_start[%0d] got %b want %b", c, got_st[c], exp_st[c]); end
    end
    checks++; if (owner_n !== 6) begin errors++; $display("FAIL b2b_accepted got %0d want 5", owner_n - 1); end
    tick();
    checks++; if (s_axis_tready !== 1'b0 || lane_busy !== 4'b1111) begin
      errors++; $display("FAIL b2b_full got tready %b busy %b want 0 1111", s_axis_tready, lane_busy); end
    lane_done = 4'b0010;
    tick();
    lane_done = '0;
    checks++; if (lane_start !== 4'b0000 || lane_busy !== 4'b1101) begin
      errors++; $display("FAIL b2b_free got start %b busy %b want 0000 1101", lane_start, lane_busy); end
    tick();
    checks++; if (lane_start !== 4'b0010 || lane_owner_programID !== 64'd5 || lane_busy !== 4'b1111) begin
      errors++; $display("FAIL b2b_reuse got start %b owner %0d busy %b want 0010 5 1111", lane_start, lane_owner_programID, lane_busy); end
  endtask

  task automatic test_conflict(input string name, input int ra, input int wa,
                               input int rb, input int wb, input bit stalls);
    do_reset();
    set_tx(1, 1, ra, wa);
    tick();
    set_tx(1, 3, rb, wb);
    tick();
    set_tx(0, 0, -1, -1);
    tick();
    if (stalls) begin
      tick(); tick();
      checks++; if (lane_start !== 4'b0000 || conflict_stall_cycles !== 32'd3 || s_axis_tready !== 1'b0) begin
        errors++; $display("FAIL %s_stall got start %b stalls %0d tready %b want 0000 3 0", name, lane_start, conflict_stall_cycles, s_axis_tready); end
      lane_done = 4'b0001;
      tick();
      lane_done = '0;
      checks++; if (lane_start !== 4'b0000 || conflict_stall_cycles !== 32'd4) begin
        errors++; $display("FAIL %s_edge got start %b stalls %0d want 0000 4", name, lane_start, conflict_stall_cycles); end
      tick();
      checks++; if (lane_start !== 4'b0001 || lane_owner_programID !== 64'd3 || conflict_stall_cycles !== 32'd4) begin
        errors++; $display("FAIL %s_release got start %b owner %0d stalls %0d want 0001 3 4", name, lane_start, lane_owner_programID, conflict_stall_cycles); end
    end else begin
      checks++; if (lane_start !== 4'b0010 || lane_owner_programID !== 64'd3 || conflict_stall_cycles !== 32'd0) begin
        errors++; $display("FAIL %s_pass got start %b owner %0d stalls %0d want 0010 3 0", name, lane_start, lane_owner_programID, conflict_stall_cycles); end
    end
  endtask

  task automatic test_done_error();
    do_reset();
    lane_done = 4'b0100;
    tick();
    lane_done = '0;
    checks++; if (done_error !== 1'b1 || completed_count !== 32'd0 || lane_busy !== 4'b0000) begin
      errors++; $display("FAIL done_err got err %b comp %0d busy %b want 1 0 0000", done_error, completed_count, lane_busy); end
    tick(); tick();
    checks++; if (done_error !== 1'b1) begin errors++; $display("FAIL done_err_sticky got %b want 1", done_error); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_tx(1, k + 1, (k < 3) ? 2 * k : -1, (k < 3) ? 2 * k + 1 : 1);
      tick();
    end
    set_tx(0, 0, -1, -1);
    checks++; if (lane_busy !== 4'b0111 || s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL mid_setup got busy %b tready %b want 0111 0", lane_busy, s_axis_tready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (lane_busy !== 4'b0000 || idle !== 1'b1 || s_axis_tready !== 1'b1 || lane_start !== 4'b0000) begin
      errors++; $display("FAIL mid_reset got busy %b idle %b tready %b start %b want 0000 1 1 0000", lane_busy, idle, s_axis_tready, lane_start); end
    checks++; if ({dispatched_count, completed_count, conflict_stall_cycles} !== 96'd0 || lane_owner_programID !== 64'd0) begin
      errors++; $display("FAIL mid_counters got %0d/%0d/%0d owner %0d want zeros", dispatched_count, completed_count, conflict_stall_cycles, lane_owner_programID); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      s_axis_tdata_owner_programID = {32'($urandom), 32'($urandom)};
      s_axis_tdata_read_dependencies = rand_dep();
      s_axis_tdata_write_dependencies = rand_dep();
      for (int i = 0; i < NL; i++)
        lane_done[i] = m_occ[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      checks++; if (s_axis_tready !== exp_tready()) begin
        errors++; bad++; if (bad < 10) $display("FAIL rand_tready c%0d got %b want %b", c, s_axis_tready, exp_tready()); end
      tick();
      checks++; if (lane_start !== m_start || lane_busy !== m_occ) begin
        errors++; bad++; if (bad < 10) $display("FAIL rand_lanes c%0d got start %b busy %b want %b %b", c, lane_start, lane_busy, m_start, m_occ); end
      checks++; if (lane_owner_programID !== m_oown || lane_read_dependencies !== m_ord || lane_write_dependencies !== m_owr) begin
        errors++; bad++; if (bad < 10) $display("FAIL rand_data c%0d got owner %h want %h", c, lane_owner_programID, m_oown); end
      checks++; if (dispatched_count !== m_disp || completed_count !== m_comp || conflict_stall_cycles !== m_stall) begin
        errors++; bad++; if (bad < 10) $display("FAIL rand_counts c%0d got %0d/%0d/%0d want %0d/%0d/%0d", c,
          dispatched_count, completed_count, conflict_stall_cycles, m_disp, m_comp, m_stall); end
      checks++; if (idle !== (!m_hv && m_occ == '0) || done_error !== m_err) begin
        errors++; bad++; if (bad < 10) $display("FAIL rand_status c%0d got idle %b err %b want %b %b", c, idle, done_error, (!m_hv && m_occ == '0), m_err); end
    end
    lane_done = '0;
    set_tx(0, 0, -1, -1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    set_tx(0, 0, -1, -1);
    lane_done = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_conflict("waw", -1, 1, -1, 1, 1);
    test_conflict("raw", -1, 1, 1, -1, 1);
    test_conflict("war", 0, -1, -1, 0, 1);
    test_conflict("rar", 0, -1, 0, -1, 0);
    test_done_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
